// File: rtl/logic_shift_unit_if.sv
// Request/response bundle for the logic/shift unit: operands and op in,
// registered result and status flags out.
interface logic_shift_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [3:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             done;
    logic             busy;
    logic             illegal;

    modport master (
        output start, op, A, B,
        input  result, zero, done, busy, illegal
    );

    modport slave (
        input  start, op, A, B,
        output result, zero, done, busy, illegal
    );
endinterface

// File: rtl/logic_shift_unit.sv
// Logic/shift unit: bitwise ops finish in one cycle, shifts and rotates
// step one bit per clock under a down-counter.
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | work register moving one bit per edge, busy high
// DONE  | result valid, done pulse; a new start is accepted here
module logic_shift_unit #(
    parameter int WIDTH = 32
) (
    input  logic                clock,
    input  logic                clear,
    logic_shift_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_OR   = 4'd1;
    localparam logic [3:0] OP_XOR  = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_NOTA = 4'd4;
    localparam logic [3:0] OP_SHL  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHRA = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;
    localparam logic [3:0] OP_ROR  = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [3:0]       sop, sop_nx;
    logic [WIDTH-1:0] result, result_nx;
    logic             zero, zero_nx;
    logic             done, done_nx;
    logic             illegal, illegal_nx;

    logic [CW-1:0]    count_in;
    logic [WIDTH-1:0] logic_val;
    logic [WIDTH-1:0] step_val;

    function automatic logic [WIDTH-1:0] shift_one(
        input logic [WIDTH-1:0] v,
        input logic [3:0]       o
    );
        case (o)
            OP_SHL:  shift_one = {v[WIDTH-2:0], 1'b0};
            OP_SHR:  shift_one = {1'b0, v[WIDTH-1:1]};
            OP_SHRA: shift_one = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROL:  shift_one = {v[WIDTH-2:0], v[WIDTH-1]};
            OP_ROR:  shift_one = {v[0], v[WIDTH-1:1]};
            default: shift_one = v;
        endcase
    endfunction

    assign count_in = bus.B[CW-1:0];
    assign step_val = shift_one(work, sop);

    always_comb begin
        logic_val = '0;
        case (bus.op)
            OP_AND:  logic_val = bus.A & bus.B;
            OP_OR:   logic_val = bus.A | bus.B;
            OP_XOR:  logic_val = bus.A ^ bus.B;
            OP_NOR:  logic_val = ~(bus.A | bus.B);
            OP_NOTA: logic_val = ~bus.A;
            default: logic_val = '0;
        endcase
    end

    always_comb begin
        state_nx   = state;
        work_nx    = work;
        cnt_nx     = cnt;
        sop_nx     = sop;
        result_nx  = result;
        zero_nx    = zero;
        done_nx    = 1'b0;
        illegal_nx = 1'b0;

        case (state)
            IDLE, DONE: begin
                state_nx = IDLE;
                if (bus.start) begin
                    if (bus.op <= OP_NOTA) begin
                        result_nx = logic_val;
                        zero_nx   = (logic_val == '0);
                        done_nx   = 1'b1;
                        state_nx  = DONE;
                    end else if (bus.op <= OP_ROR) begin
                        if (count_in == '0) begin
                            result_nx = bus.A;
                            zero_nx   = (bus.A == '0);
                            done_nx   = 1'b1;
                            state_nx  = DONE;
                        end else begin
                            work_nx  = bus.A;
                            cnt_nx   = count_in;
                            sop_nx   = bus.op;
                            state_nx = SHIFT;
                        end
                    end else begin
                        result_nx  = '0;
                        zero_nx    = 1'b1;
                        done_nx    = 1'b1;
                        illegal_nx = 1'b1;
                        state_nx   = DONE;
                    end
                end
            end
            SHIFT: begin
                work_nx = step_val;
                cnt_nx  = cnt - CW'(1);
                // Terminal count: this edge performs the last bit move.
                if (cnt == CW'(1)) begin
                    result_nx = step_val;
                    zero_nx   = (step_val == '0);
                    done_nx   = 1'b1;
                    state_nx  = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            work    <= '0;
            cnt     <= '0;
            sop     <= '0;
            result  <= '0;
            zero    <= 1'b1;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            state   <= state_nx;
            work    <= work_nx;
            cnt     <= cnt_nx;
            sop     <= sop_nx;
            result  <= result_nx;
            zero    <= zero_nx;
            done    <= done_nx;
            illegal <= illegal_nx;
        end
    end

    assign bus.result  = result;
    assign bus.zero    = zero;
    assign bus.done    = done;
    assign bus.illegal = illegal;
    assign bus.busy    = (state == SHIFT);
endmodule

// File: tb/tb_logic_shift_unit.sv
// Directed bench for logic_shift_unit at WIDTH=32 with hand-computed expectations.
module tb_logic_shift_unit;
    localparam int WIDTH = 32;

    logic clock;
    logic clear;
    int   total;
    int   bad;
    int   n;

    logic_shift_unit_if #(.WIDTH(WIDTH)) lsu ();

    logic_shift_unit #(.WIDTH(WIDTH)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (lsu.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        lsu.start = 1'b1;
        lsu.op    = o;
        lsu.A     = a;
        lsu.B     = b;
        tick();
        lsu.start = 1'b0;
    endtask

    // Counts busy cycles until done, bounded; a missing done is a failure.
    task automatic wait_done(output int busy_cycles);
        int guard;
        busy_cycles = 0;
        guard = 0;
        while (!lsu.done && guard < 200) begin
            if (lsu.busy) busy_cycles++;
            tick();
            guard++;
        end
        chk("done_seen", {63'd0, lsu.done}, 64'd1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        clear = 1'b1;
        lsu.start = 1'b0;
        lsu.op    = 4'd0;
        lsu.A     = '0;
        lsu.B     = '0;
        tick();
        tick();
        chk("rst_result", lsu.result, 0);
        chk("rst_zero", lsu.zero, 1);
        chk("rst_done", lsu.done, 0);
        chk("rst_busy", lsu.busy, 0);
        chk("rst_illegal", lsu.illegal, 0);
        clear = 1'b0;
        tick();

        go(4'd0, 32'd7, 32'd5);
        chk("and_result", lsu.result, 5);
        chk("and_zero", lsu.zero, 0);
        chk("and_done", lsu.done, 1);
        chk("and_busy", lsu.busy, 0);
        tick();
        chk("and_done_drop", lsu.done, 0);
        chk("and_hold", lsu.result, 5);
        go(4'd1, 32'd6, 32'd2);
        chk("or_result", lsu.result, 6);
        chk("or_done", lsu.done, 1);
        tick();

        clear = 1'b1;
        go(4'd1, 32'hF, 32'hF);
        clear = 1'b0;
        chk("clr_prio_result", lsu.result, 0);
        chk("clr_prio_done", lsu.done, 0);
        chk("clr_prio_zero", lsu.zero, 1);
        tick();

        go(4'd5, 32'd1, 32'd4);
        chk("shl_busy0", lsu.busy, 1);
        chk("shl_done0", lsu.done, 0);
        lsu.start = 1'b1;
        lsu.op    = 4'd0;
        lsu.A     = '0;
        lsu.B     = '0;
        tick();
        lsu.start = 1'b0;
        chk("shl_ignored_busy", lsu.busy, 1);
        wait_done(n);
        chk("shl_busy_rest", n, 3);
        chk("shl_result", lsu.result, 16);
        tick();
        chk("shl_after_done", lsu.done, 0);
        chk("shl_after_result", lsu.result, 16);

        go(4'd7, 32'h8000_0000, 32'd31);
        wait_done(n);
        chk("shra_busy", n, 31);
        chk("shra_result", lsu.result, 32'hFFFF_FFFF);
        chk("shra_zero", lsu.zero, 0);
        tick();

        go(4'd9, 32'd1, 32'd33);
        wait_done(n);
        chk("ror_busy", n, 1);
        chk("ror_result", lsu.result, 32'h8000_0000);
        tick();

        go(4'd8, 32'h8000_0001, 32'd4);
        wait_done(n);
        chk("rol_busy", n, 4);
        chk("rol_result", lsu.result, 32'h0000_0018);
        tick();

        go(4'd8, 32'h1234_5678, 32'd0);
        chk("rol0_done", lsu.done, 1);
        chk("rol0_busy", lsu.busy, 0);
        chk("rol0_result", lsu.result, 32'h1234_5678);
        tick();

        go(4'd12, 32'h1234_5678, 32'h1);
        chk("ill_result", lsu.result, 0);
        chk("ill_zero", lsu.zero, 1);
        chk("ill_done", lsu.done, 1);
        chk("ill_flag", lsu.illegal, 1);
        tick();
        chk("ill_flag_drop", lsu.illegal, 0);
        chk("ill_done_drop", lsu.done, 0);
        chk("ill_zero_hold", lsu.zero, 1);

        go(4'd1, 32'h55, 32'h0);
        tick();
        go(4'd6, 32'hFFFF_FFFF, 32'd10);
        tick();
        tick();
        chk("abort_busy_pre", lsu.busy, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("abort_busy", lsu.busy, 0);
        chk("abort_done", lsu.done, 0);
        chk("abort_result", lsu.result, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_no_done", lsu.done, 0);
        end

        go(4'd6, 32'h0000_FF00, 32'd4);
        wait_done(n);
        chk("shr_busy", n, 4);
        chk("shr_result", lsu.result, 32'h0000_0FF0);
        chk("b2b_done_first", lsu.done, 1);
        go(4'd2, 32'hF0, 32'hFF);
        chk("b2b_done_second", lsu.done, 1);
        chk("b2b_result", lsu.result, 32'h0F);
        tick();
        chk("b2b_done_drop", lsu.done, 0);
        chk("b2b_hold", lsu.result, 32'h0F);

        go(4'd3, 32'hFFFF_0000, 32'h0000_FFFF);
        chk("nor_result", lsu.result, 0);
        chk("nor_zero", lsu.zero, 1);
        tick();
        go(4'd4, 32'h0F0F_0F0F, 32'h0);
        chk("not_result", lsu.result, 32'hF0F0_F0F0);
        chk("not_zero", lsu.zero, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/logic_shift_unit.md
LOGIC_SHIFT_UNIT -- requirements
Module: logic_shift_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are powers of two from 8 to 64.
REQ-002 SHALL derive CW = log2(WIDTH), the shift-count width; this is not overridable.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  request; sampled on the rising edge of clock.
REQ-006 SHALL have port op  input  4  operation select, sampled with start.
REQ-007 SHALL have port A  input  WIDTH  first operand / shift source.
REQ-008 SHALL have port B  input  WIDTH  second operand; B[CW-1:0] is the shift count.
REQ-009 SHALL have port result  output  WIDTH  registered result, held until the next completion.
REQ-010 SHALL have port zero  output  1  registered; high when result == 0, updated with result.
REQ-011 SHALL have port done  output  1  registered one-cycle completion pulse.
REQ-012 SHALL have port busy  output  1  high while a shift is in progress.
REQ-013 SHALL have port illegal  output  1  registered; pulses with done for an undefined op.

Function
REQ-014 SHALL use op encoding: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 NOT A, 5 SHL, 6 SHR (logical), 7 SHRA (arithmetic), 8 ROL, 9 ROR, 10-15 undefined.
REQ-015 SHALL implement states IDLE, SHIFT and DONE, with busy = (state == SHIFT).
REQ-016 SHALL accept start in IDLE or DONE and ignore start while in SHIFT; an ignored request leaves no trace.
REQ-017 For ops 0-4 accepted at edge k, SHALL load result at edge k, enter DONE, and drive done high for one cycle (latency 1).
REQ-018 For ops 5-9 with n = B[CW-1:0] > 0, SHALL latch A into a work register and n into a counter at edge k, then enter SHIFT.
REQ-019 In SHIFT, SHALL move the work register by exactly one bit position per edge and decrement the counter.
REQ-020 On the shift edge where the counter reaches 0, SHALL load the final value into result and enter DONE; done is therefore asserted after edge k+n, and busy is high for n cycles.
REQ-021 For ops 5-9 with n = 0, SHALL load result = A at edge k and complete as a logic op (latency 1).
REQ-022 SHALL ignore B[WIDTH-1:CW] for the shift ops.
REQ-023 SHALL shift in zeros for SHL and SHR.
REQ-024 SHALL replicate the sign bit for SHRA.
REQ-025 For ROL, SHALL rotate the MSB into the LSB; for ROR, SHALL rotate the LSB into the MSB.
REQ-026 For ops 10-15, SHALL set result = 0, zero = 1, done = 1 and illegal = 1 with latency 1.
REQ-027 From DONE with no new start, SHALL return to IDLE next edge; done and illegal deassert, result and zero hold.
REQ-028 SHALL allow back-to-back operation: start accepted in DONE begins a new op, and a new logic op keeps done high for a further cycle with the new result.
REQ-029 SHALL register operands at acceptance, so changes on A, B or op during SHIFT do not affect the operation.

Reset
REQ-030 When clear = 1 at a rising edge, SHALL force state = IDLE, result = 0, zero = 1, done = 0, busy = 0, illegal = 0, and clear the counter and work register.
REQ-031 SHALL give clear priority over start; a start on a clear edge is discarded.
REQ-032 On clear mid-SHIFT, SHALL abort the operation with no done pulse, and result reads 0 afterwards.

Verification (WIDTH = 32)
REQ-033 A=7, B=5, op=0, start one cycle -> result=5, zero=0, done high exactly one cycle after acceptance; then op=1, A=6, B=2 -> result=6.
REQ-034 A=1, B=4, op=5 -> busy high 4 cycles, done after edge k+4, result=16; start pulsed during busy is ignored and result is unchanged.
REQ-035 A=0x80000000, B=31, op=7 -> result=0xFFFFFFFF after 31 cycles; A=1, B=33, op=9 -> count 1, result=0x80000000, latency 1.
REQ-036 A=0x12345678, B=0, op=8 -> result=0x12345678, done after 1 cycle; op=12 -> result=0, zero=1, illegal and done pulse together.
REQ-037 op=6, A=0xFFFFFFFF, B=10, clear asserted on the 3rd SHIFT cycle -> no done, busy=0, result=0 on the next cycle, next start behaves normally.
REQ-038 Back-to-back: op=2 (A=0xF0, B=0xFF) accepted in the DONE cycle of a prior op -> done stays high two consecutive cycles, final result=0x0F.
